team_06_delay_buffer: RTL and testbench
=======================================

TEAM_06_DELAY_BUFFER -- requirements
Module: team_06_delay_buffer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: sample_strobe  input  1  one-cycle pulse marking a new audio sample period.
REQ-004 SHALL have port: save_audio  input  8  unsigned sample to store this period.
REQ-005 SHALL have port: offset  input  13  delay in samples for the read-back, 0..8191.
REQ-006 SHALL have port: past_output  output  8  delayed sample returned to the echo/reverb effect.
REQ-007 SHALL have port: past_valid  output  1  one-cycle pulse when past_output updates.
REQ-008 SHALL have port: busy  output  1  high while a write/read sequence is in progress.
REQ-009 SHALL have port: overrun  output  1  sticky flag, strobe arrived while busy.
REQ-010 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out 13, mem_wdata out 8, mem_rdata in 8, mem_ack in 1  single-port external sample SRAM.

Function
REQ-011 SHALL implement a circular delay line of 8192 8-bit samples; wr_ptr (13-bit) wraps 8191 -> 0.
REQ-012 SHALL use FSM states IDLE, WRITE, READ, DONE.
REQ-013 IDLE: on sample_strobe, latch save_audio and offset, go to WRITE next cycle; busy high from the following cycle.
REQ-014 WRITE: mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=latched sample, all held stable until mem_ack sampled high.
REQ-015 On write ack: wr_ptr increments (mod 8192), fill count increments saturating at 8192, go to READ (or DONE if REQ-018/019 applies).
REQ-016 READ: mem_req=1, mem_we=0, mem_addr = (written address - latched offset) mod 8192, held until mem_ack.
REQ-017 On read ack: register mem_rdata into past_output, go to DONE.
REQ-018 Latched offset = 0: skip READ; past_output = latched sample.
REQ-019 Latched offset >= samples written since reset (fill count before this write): skip READ; past_output = 0 (no stale RAM data).
REQ-020 DONE: past_valid=1 for exactly one cycle, busy=0, return to IDLE.
REQ-021 mem_req SHALL drop in the cycle after ack; mem_ack while mem_req=0 ignored.
REQ-022 Latency with same-cycle ack: strobe at cycle N -> write req N+1, read req N+2, past_valid and new past_output at N+3.
REQ-023 Strobe while busy (any state but IDLE) SHALL be dropped, overrun set; in-flight sequence unaffected.
REQ-024 Strobe in the DONE cycle SHALL be accepted normally (DONE counts as idle for acceptance).
REQ-025 past_output SHALL hold its value between past_valid pulses.
REQ-026 Offset/save_audio changes after strobe SHALL not affect the in-flight sequence.

Reset
REQ-027 rst SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 rst SHALL clear wr_ptr, fill count, past_output=0, past_valid=0, busy=0, overrun=0.
REQ-029 rst mid-transaction SHALL abandon the access; a late mem_ack after release SHALL be ignored.

Structure
REQ-030 team_06_pkg SHALL hold DELAY_DEPTH=8192, ADDR_W=13, SAMPLE_W=8 and the FSM state enum typedef.
REQ-031 Pointer, fill counter and FSM SHALL reside in one module; no sub-module required.

Verification
REQ-032 Reset, then strobe save_audio=68 offset=0, ack same cycle -> write addr 0, no read, past_output=68, past_valid at N+3-1 (N+2).
REQ-033 Write 10 samples 1..10, then strobe save_audio=11 offset=3 -> read addr 7, mem_rdata=8 returned, past_output=8.
REQ-034 After reset, strobe offset=5 with only 2 samples written -> no read issued, past_output=0.
REQ-035 Ack delayed 4 cycles on write -> mem_req/addr/wdata stable all 4 cycles; second strobe during wait -> dropped, overrun=1.
REQ-036 Write 8192 samples, next write -> addr 0 (wrap); offset=8191 -> read addr 1.
REQ-037 Assert rst while mem_req high in READ -> mem_req=0 same cycle, all outputs 0; ack after release ignored.

Source files
------------

// File: rtl/team_06_pkg.sv
// rtl/team_06_pkg.sv - shared sizes and FSM state type for the sample delay line
package team_06_pkg;
    localparam int DELAY_DEPTH = 8192;
    localparam int ADDR_W      = 13;
    localparam int SAMPLE_W    = 8;
    localparam int FILL_W      = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;
endpackage

// File: rtl/team_06_delay_buffer.sv
// rtl/team_06_delay_buffer.sv - circular sample delay line over a single-port external SRAM
module team_06_delay_buffer
    import team_06_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_strobe,
    input  logic [SAMPLE_W-1:0] save_audio,
    input  logic [ADDR_W-1:0]   offset,
    output logic [SAMPLE_W-1:0] past_output,
    output logic                past_valid,
    output logic                busy,
    output logic                overrun,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [SAMPLE_W-1:0] mem_wdata,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    input  logic                mem_ack
);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DELAY_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] off_q;
    logic [FILL_W-1:0] fill_cnt;
    logic              can_accept;
    logic              skip_read;

    // DONE is treated as idle so back-to-back strobes are not lost
    assign can_accept = (state == IDLE) || (state == DONE);
    // Zero delay returns the fresh sample; a delay reaching past the fill level returns silence
    assign skip_read  = (off_q == '0) || ({1'b0, off_q} >= fill_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            off_q       <= '0;
            fill_cnt    <= '0;
            past_output <= '0;
            past_valid  <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            past_valid <= 1'b0;
            if (sample_strobe && !can_accept) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (sample_strobe) begin
                        off_q     <= offset;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= save_audio;
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill_cnt != FILL_MAX) begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                        if (skip_read) begin
                            past_output <= (off_q == '0) ? mem_wdata : '0;
                            mem_req     <= 1'b0;
                            mem_we      <= 1'b0;
                            past_valid  <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= mem_addr - off_q;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (mem_ack) begin
                        past_output <= mem_rdata;
                        mem_req     <= 1'b0;
                        past_valid  <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_team_06_delay_buffer.sv
// tb/tb_team_06_delay_buffer.sv - self-checking bench for team_06_delay_buffer
module tb_team_06_delay_buffer;
    logic        clk;
    logic        rst;
    logic        sample_strobe;
    logic [7:0]  save_audio;
    logic [12:0] offset;
    logic [7:0]  past_output;
    logic        past_valid;
    logic        busy;
    logic        overrun;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    team_06_delay_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_strobe(sample_strobe),
        .save_audio   (save_audio),
        .offset       (offset),
        .past_output  (past_output),
        .past_valid   (past_valid),
        .busy         (busy),
        .overrun      (overrun),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int s;
        int off;
        int dly;
        int eo;
        bit rd;
        int ra;
    } vec_t;

    typedef struct {
        bit we;
        int addr;
        int data;
    } acc_t;

    int          passed = 0;
    int          total = 0;
    int          history[$];
    acc_t        acc_log[$];
    logic [7:0]  mem [0:8191];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          late_ack_n = 0;
    int          stab_err = 0;
    logic [12:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;

    task automatic cmp(input string name, input int got, input int exp, input bit rec, inout bit ok);
        if (rec) begin
            total++;
            if (got == exp) passed++;
            else $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else if (got != exp) begin
            ok = 1'b0;
        end
    endtask

    // SRAM model: acks after ack_delay wait cycles and checks the request stays stable meanwhile
    task automatic respond();
        if (late_ack_n > 0) begin
            mem_ack = 1'b1;
            late_ack_n--;
        end else if (mem_req) begin
            if (wait_cnt == 0) begin
                req_addr  = mem_addr;
                req_we    = mem_we;
                req_wdata = mem_wdata;
            end else if (mem_addr != req_addr || mem_we != req_we || mem_wdata != req_wdata) begin
                stab_err++;
            end
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else mem_rdata = mem[mem_addr];
                acc_log.push_back('{mem_we, int'(mem_addr), int'(mem_wdata)});
                wait_cnt = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        respond();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_strobe = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        history.delete();
        cyc();
    endtask

    // Reference: sample k lands at k mod depth; delay d returns sample k-d if it exists
    task automatic model(input int off, output int eo, output bit er, output int ea);
        int cnt;
        cnt = history.size();
        er = 1'b0;
        ea = 0;
        if (off == 0) eo = -1;
        else if (off >= cnt) eo = 0;
        else begin
            er = 1'b1;
            ea = (cnt - off) % 8192;
            eo = history[cnt - off];
        end
    endtask

    task automatic do_sample(input int s, input int off, input int dly, input int dup_at,
                             input bit b2b, input bit rec, input int exp_out, input bit exp_rd,
                             input int exp_ra, output bit ok);
        int lat;
        int wa;
        int exp_lat;
        ok = 1'b1;
        wa = history.size() % 8192;
        acc_log.delete();
        stab_err = 0;
        ack_delay = dly;
        save_audio = 8'(s);
        offset = 13'(off);
        sample_strobe = 1'b1;
        cyc();
        sample_strobe = 1'b0;
        save_audio = 8'($urandom);
        offset = 13'($urandom);
        cmp("busy_after_strobe", busy, 1, rec, ok);
        lat = 1;
        while (!past_valid && lat < 80) begin
            sample_strobe = (dup_at != 0 && lat == dup_at);
            cyc();
            lat++;
        end
        sample_strobe = 1'b0;
        history.push_back(s & 255);
        exp_lat = 2 + dly + (exp_rd ? 1 + dly : 0);
        cmp("no_timeout", int'(lat < 80), 1, rec, ok);
        cmp("latency", lat, exp_lat, rec, ok);
        cmp("past_output", past_output, exp_out, rec, ok);
        cmp("busy_in_done", busy, 0, rec, ok);
        cmp("access_count", acc_log.size(), exp_rd ? 2 : 1, rec, ok);
        cmp("request_stable", stab_err, 0, rec, ok);
        if (acc_log.size() >= 1) begin
            cmp("write_we", acc_log[0].we, 1, rec, ok);
            cmp("write_addr", acc_log[0].addr, wa, rec, ok);
            cmp("write_data", acc_log[0].data, s & 255, rec, ok);
        end
        if (exp_rd && acc_log.size() >= 2) begin
            cmp("read_we", acc_log[1].we, 0, rec, ok);
            cmp("read_addr", acc_log[1].addr, exp_ra, rec, ok);
        end
        if (!b2b) begin
            cyc();
            cmp("valid_one_cycle", past_valid, 0, rec, ok);
            cmp("output_held", past_output, exp_out, rec, ok);
            cmp("req_dropped", mem_req, 0, rec, ok);
        end
    endtask

    task automatic model_sample(input int s, input int off, input int dly, input bit b2b);
        int eo;
        int ea;
        bit er;
        bit ok;
        model(off, eo, er, ea);
        if (eo < 0) eo = s & 255;
        do_sample(s, off, dly, 0, b2b, 1'b1, eo, er, ea, ok);
    endtask

    initial begin
        vec_t tbl[7];
        bit   ok;
        bit   bulk_ok;
        int   lat;
        int   bad;
        rst = 1'b1;
        sample_strobe = 1'b0;
        save_audio = '0;
        offset = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(1, 255));
        tbl[0] = '{68, 0, 0, 68, 1'b0, 0};
        tbl[1] = '{20, 0, 1, 20, 1'b0, 0};
        tbl[2] = '{30, 5, 0, 0, 1'b0, 0};
        tbl[3] = '{40, 3, 0, 0, 1'b0, 0};
        tbl[4] = '{50, 2, 0, 30, 1'b1, 2};
        tbl[5] = '{60, 1, 2, 50, 1'b1, 4};
        tbl[6] = '{70, 5, 1, 20, 1'b1, 1};

        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cmp("rst_mem_req", mem_req, 0, 1'b1, ok);
        cmp("rst_mem_we", mem_we, 0, 1'b1, ok);
        cmp("rst_mem_addr", mem_addr, 0, 1'b1, ok);
        cmp("rst_mem_wdata", mem_wdata, 0, 1'b1, ok);
        cmp("rst_past_output", past_output, 0, 1'b1, ok);
        cmp("rst_past_valid", past_valid, 0, 1'b1, ok);
        cmp("rst_busy", busy, 0, 1'b1, ok);
        cmp("rst_overrun", overrun, 0, 1'b1, ok);

        for (int i = 0; i < 7; i++)
            do_sample(tbl[i].s, tbl[i].off, tbl[i].dly, 0, 1'b0, 1'b1,
                      tbl[i].eo, tbl[i].rd, tbl[i].ra, ok);
        cmp("table_no_overrun", overrun, 0, 1'b1, ok);

        do_reset();
        for (int i = 1; i <= 10; i++) do_sample(i, 0, 0, 0, 1'b0, 1'b1, i, 1'b0, 0, ok);
        do_sample(11, 3, 0, 0, 1'b0, 1'b1, 8, 1'b1, 7, ok);

        do_sample(123, 2, 4, 2, 1'b0, 1'b1, 10, 1'b1, 9, ok);
        cmp("overrun_set", overrun, 1, 1'b1, ok);
        cyc();
        cmp("dropped_strobe_idle", int'(busy || mem_req), 0, 1'b1, ok);

        do_reset();
        for (int i = 0; i < 60; i++)
            model_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        cyc();
        cmp("b2b_no_overrun", overrun, 0, 1'b1, ok);

        do_reset();
        bulk_ok = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            do_sample(i & 255, 0, 0, 0, 1'b1, 1'b0, i & 255, 1'b0, 0, ok);
            bulk_ok &= ok;
        end
        cyc();
        cmp("bulk_fill", bulk_ok, 1, 1'b1, ok);
        do_sample(77, 8191, 0, 0, 1'b0, 1'b1, 1, 1'b1, 1, ok);
        for (int i = 0; i < 150; i++)
            model_sample(int'($urandom_range(0, 255)),
                         ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8191)),
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        cyc();

        ack_delay = 3;
        save_audio = 8'd99;
        offset = 13'd1;
        sample_strobe = 1'b1;
        cyc();
        sample_strobe = 1'b0;
        lat = 0;
        while (!(mem_req && !mem_we) && lat < 40) begin
            cyc();
            lat++;
        end
        cmp("read_phase_reached", int'(mem_req && !mem_we), 1, 1'b1, ok);
        rst = 1'b1;
        #1;
        cmp("arst_mem_req", mem_req, 0, 1'b1, ok);
        cmp("arst_mem_we", mem_we, 0, 1'b1, ok);
        cmp("arst_mem_addr", mem_addr, 0, 1'b1, ok);
        cmp("arst_mem_wdata", mem_wdata, 0, 1'b1, ok);
        cmp("arst_flags", int'({past_valid, busy, overrun}), 0, 1'b1, ok);
        cmp("arst_past_output", past_output, 0, 1'b1, ok);
        cyc();
        rst = 1'b0;
        history.delete();
        late_ack_n = 2;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (past_valid || busy || mem_req) bad++;
        end
        cmp("late_ack_ignored", bad, 0, 1'b1, ok);
        cmp("late_ack_output", past_output, 0, 1'b1, ok);
        do_sample(5, 0, 0, 0, 1'b0, 1'b1, 5, 1'b0, 0, ok);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
